// File: rtl/apu_joypad_ports_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_joypad_ports_if
// Brief    : APU register-space bus between the CPU side and the joypad ports.
// Revision : 1.0 - initial release
// ============================================================================
interface apu_joypad_ports_if;
    logic       cs;
    logic [4:0] addr;
    logic       rw;
    logic       cpu_en;
    logic [7:0] wdata;
    logic [7:0] open_bus_i;
    logic [7:0] rdata;
    logic       rdata_valid;

    modport master (
        output cs, addr, rw, cpu_en, wdata, open_bus_i,
        input  rdata, rdata_valid
    );

    modport slave (
        input  cs, addr, rw, cpu_en, wdata, open_bus_i,
        output rdata, rdata_valid
    );
endinterface
`default_nettype wire

// File: rtl/apu_joypad_ports.sv
`default_nettype none
// ============================================================================
// Module   : apu_joypad_ports
// Brief    : $4016/$4017 NES controller ports: strobe latch, serial shift
//            chains with optional Four Score signature, open-bus upper bits.
// Revision : 1.0 - initial release
// ============================================================================
module apu_joypad_ports #(
    parameter int         NUM_PORTS     = 2,
    parameter int         PADS_PER_PORT = 1,
    parameter logic [7:0] OPEN_BUS_MASK = 8'hE0
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst,
    apu_joypad_ports_if.slave                           bus,
    input  wire logic [8*NUM_PORTS*PADS_PER_PORT-1:0]   pad_buttons,
    output logic      [2:0]                             strobe_o,
    output logic      [NUM_PORTS-1:0]                   read_pulse_o
);

    localparam int         CHAIN_LEN = 8*PADS_PER_PORT + ((PADS_PER_PORT == 2) ? 8 : 0);
    localparam int         CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [4:0] ADDR_P0   = 5'h16;

    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [NUM_PORTS-1:0] w_port_hit;
    logic [NUM_PORTS-1:0] w_bit0;
    logic                 w_sel_bit;

    logic [2:0]           strobe_q, strobe_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic [NUM_PORTS-1:0] read_pulse_q, read_pulse_d;

    assign w_wr_acc = bus.cs & ~bus.rw & bus.cpu_en;
    assign w_rd_acc = bus.cs &  bus.rw & bus.cpu_en;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [4:0] PORT_ADDR = ADDR_P0 + 5'(p);

        logic [CHAIN_LEN-1:0] w_reload;
        logic [CHAIN_LEN-1:0] chain_q, chain_d;
        logic [CNT_W-1:0]     cnt_q, cnt_d;
        logic                 w_done;

        assign w_port_hit[p] = (bus.addr == PORT_ADDR);

        // Slot j of port p carries pad j*NUM_PORTS+p, so Four Score pads interleave across ports.
        for (genvar j = 0; j < PADS_PER_PORT; j++) begin : g_slot
            assign w_reload[8*j +: 8] = pad_buttons[8*(j*NUM_PORTS + p) +: 8];
        end

        if (PADS_PER_PORT == 2) begin : g_sig
            assign w_reload[CHAIN_LEN-1 -: 8] = (p == 0) ? 8'h10 : 8'h20;
        end

        assign w_done = (cnt_q == CNT_W'(CHAIN_LEN));

        // With the strobe high the pads are transparent: report the live A button.
        assign w_bit0[p] = strobe_q[0] ? w_reload[0] : (w_done | chain_q[0]);

        always_comb begin
            chain_d = chain_q;
            cnt_d   = cnt_q;
            if (strobe_q[0]) begin
                chain_d = w_reload;
                cnt_d   = '0;
            end else if (w_rd_acc && w_port_hit[p]) begin
                chain_d = {1'b1, chain_q[CHAIN_LEN-1:1]};
                if (!w_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                chain_q <= '1;
                cnt_q   <= CNT_W'(CHAIN_LEN);
            end else begin
                chain_q <= chain_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    always_comb begin
        w_sel_bit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_port_hit[p]) begin
                w_sel_bit = w_bit0[p];
            end
        end
    end

    always_comb begin
        strobe_d      = strobe_q;
        rdata_d       = rdata_q;
        rdata_valid_d = w_rd_acc;
        read_pulse_d  = w_rd_acc ? w_port_hit : '0;
        if (w_wr_acc && (bus.addr == ADDR_P0)) begin
            strobe_d = bus.wdata[2:0];
        end
        if (w_rd_acc) begin
            rdata_d = (bus.open_bus_i & OPEN_BUS_MASK) | {7'b0, w_sel_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            read_pulse_q  <= '0;
        end else begin
            strobe_q      <= strobe_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            read_pulse_q  <= read_pulse_d;
        end
    end

    assign strobe_o        = strobe_q;
    assign read_pulse_o    = read_pulse_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire
